// File: rtl/calc1_req_sched_pkg.sv
// Shared types and encodings for the CALC1 request scheduler.
package calc1_sched_pkg;

   // scheduler sequencing states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_OP2,
      ST_WAIT,
      ST_RSP
   } sched_state_e;

   // CALC1 command codes
   localparam logic [3:0] CMD_NOP = 4'd0;
   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   // CALC1 / scheduler response codes
   localparam logic [1:0] RESP_NONE    = 2'd0;
   localparam logic [1:0] RESP_OK      = 2'd1;
   localparam logic [1:0] RESP_ERR     = 2'd2;
   localparam logic [1:0] RESP_TIMEOUT = 2'd3;

   // the part of an accepted request still needed after the acceptance cycle
   typedef struct packed {
      logic [3:0]  cmd;
      logic [31:0] op2;
   } pend_t;

endpackage

// File: rtl/calc1_req_sched_if.sv
// Requester and CALC1 port bundle for calc1_req_sched.
// slave = scheduler side, master = requesters plus CALC1 model side.
interface calc1_req_sched_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [NUM_REQ-1:0][3:0]   req_cmd;
   logic [NUM_REQ-1:0][31:0]  req_op1;
   logic [NUM_REQ-1:0][31:0]  req_op2;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [1:0]                rsp_resp;
   logic [31:0]               rsp_data;
   logic [3:0]                calc_cmd;
   logic [31:0]               calc_data_in;
   logic [1:0]                calc_resp;
   logic [31:0]               calc_data_out;

   modport slave (
      input  req_valid, req_cmd, req_op1, req_op2, calc_resp, calc_data_out,
      output req_ready, rsp_valid, rsp_resp, rsp_data, calc_cmd, calc_data_in
   );

   modport master (
      output req_valid, req_cmd, req_op1, req_op2, calc_resp, calc_data_out,
      input  req_ready, rsp_valid, rsp_resp, rsp_data, calc_cmd, calc_data_in
   );
endinterface

// File: rtl/calc1_req_sched_arb.sv
// Round-robin arbiter: the search starts one past the last granted
// requester and wraps, so every requester is served within NUM_REQ grants.
module calc1_rr_arb #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] last_grant,
   output logic [NUM_REQ-1:0]         grant
);
   localparam int LGW = $clog2(NUM_REQ);

   logic           found;
   int             pos;
   logic [LGW-1:0] idx;

   // first active requester after last_grant, wrapping past NUM_REQ-1
   always_comb begin
      grant = '0;
      found = 1'b0;
      pos   = 0;
      idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         pos = int'(last_grant) + i;
         if (pos >= NUM_REQ) pos = pos - NUM_REQ;
         idx = LGW'(pos);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/calc1_req_sched.sv
// calc1_req_sched: shares one CALC1 port among NUM_REQ requesters, one
// command in flight at a time. Optional WAIT timeout is built when the
// macro CALC1_SCHED_TIMEOUT_EN is defined.
module calc1_req_sched
   import calc1_sched_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic             c_clk,
   input  logic             reset,
   calc1_req_sched_if.slave bus,
   output logic             busy,
   output logic             timeout_err
);
   localparam int LGW   = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

   sched_state_e        state;
   logic [LGW-1:0]      last_grant;
   logic [LGW-1:0]      gnt_idx;
   logic [LGW-1:0]      cur_idx;
   logic [NUM_REQ-1:0]  grant;
   pend_t               pend;

`ifdef CALC1_SCHED_TIMEOUT_EN
   logic [CNT_W-1:0]    wait_cnt;
   logic                tmo_err;
   assign timeout_err = tmo_err;
`else
   logic [CNT_W-1:0]    unused_tmo;
   assign unused_tmo  = '0;
   assign timeout_err = 1'b0;
`endif

   calc1_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
      .req        (bus.req_valid),
      .last_grant (last_grant),
      .grant      (grant)
   );

   // one-hot grant to index for operand selection
   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (grant[i]) gnt_idx = LGW'(i);
   end

   // acceptance is offered only from IDLE and never while reset is held
   assign bus.req_ready = (reset && state == ST_IDLE) ? grant : '0;
   assign busy          = (state != ST_IDLE);

   // sequencer: accept, present cmd/op1, present op2, wait for CALC1, respond
   always_ff @(posedge c_clk) begin
      if (!reset) begin
         state            <= ST_IDLE;
         last_grant       <= LGW'(NUM_REQ - 1);
         cur_idx          <= '0;
         pend             <= '0;
         bus.calc_cmd     <= '0;
         bus.calc_data_in <= '0;
         bus.rsp_valid    <= '0;
         bus.rsp_resp     <= RESP_NONE;
         bus.rsp_data     <= '0;
`ifdef CALC1_SCHED_TIMEOUT_EN
         wait_cnt         <= '0;
         tmo_err          <= 1'b0;
`endif
      end else begin
         bus.rsp_valid <= '0;
         case (state)
            ST_IDLE: begin
               if (|bus.req_valid) begin
                  cur_idx          <= gnt_idx;
                  pend.cmd         <= bus.req_cmd[gnt_idx];
                  pend.op2         <= bus.req_op2[gnt_idx];
                  // a nop never reaches the CALC1 port, so nothing is driven for it
                  bus.calc_cmd     <= bus.req_cmd[gnt_idx];
                  bus.calc_data_in <= (bus.req_cmd[gnt_idx] == CMD_NOP) ? '0
                                                                        : bus.req_op1[gnt_idx];
                  state            <= ST_CMD;
               end
            end
            ST_CMD: begin
               if (pend.cmd == CMD_NOP) begin
                  // nop is answered locally with err, bypassing the CALC1 exchange
                  bus.rsp_valid <= ONE << cur_idx;
                  bus.rsp_resp  <= RESP_ERR;
                  bus.rsp_data  <= '0;
                  state         <= ST_RSP;
               end else begin
                  bus.calc_cmd     <= '0;
                  bus.calc_data_in <= pend.op2;
                  state            <= ST_OP2;
               end
            end
            ST_OP2: begin
               bus.calc_data_in <= '0;
               state            <= ST_WAIT;
`ifdef CALC1_SCHED_TIMEOUT_EN
               wait_cnt         <= '0;
`endif
            end
            ST_WAIT: begin
               if (bus.calc_resp != RESP_NONE) begin
                  bus.rsp_valid <= ONE << cur_idx;
                  bus.rsp_resp  <= bus.calc_resp;
                  bus.rsp_data  <= bus.calc_data_out;
                  state         <= ST_RSP;
               end
`ifdef CALC1_SCHED_TIMEOUT_EN
               else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  bus.rsp_valid <= ONE << cur_idx;
                  bus.rsp_resp  <= RESP_TIMEOUT;
                  bus.rsp_data  <= '0;
                  tmo_err       <= 1'b1;
                  state         <= ST_RSP;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
`endif
            end
            ST_RSP: begin
               last_grant   <= cur_idx;
               bus.rsp_resp <= RESP_NONE;
               bus.rsp_data <= '0;
               state        <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_calc1_req_sched.sv
// Self-checking bench for calc1_req_sched: directed scenarios plus a
// randomized run against a transaction-level round-robin/latency model.
module tb_calc1_req_sched;
   localparam int N = 4;

   logic c_clk;
   logic reset;
   logic busy;
   logic timeout_err;

   calc1_req_sched_if #(.NUM_REQ(N)) bus ();

   calc1_req_sched #(.NUM_REQ(N), .TIMEOUT_CYC(64)) dut (
      .c_clk       (c_clk),
      .reset       (reset),
      .bus         (bus),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   initial c_clk = 1'b0;
   always #5 c_clk = ~c_clk;

   int          total;
   int          bad;
   int          ptr;            // model: last granted requester
   logic [3:0]  vmask;
   logic [3:0]  cmd_a [N];
   logic [31:0] op1_a [N];
   logic [31:0] op2_a [N];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive_reqs();
      bus.req_valid = vmask;
      for (int i = 0; i < N; i++) begin
         bus.req_cmd[i] = cmd_a[i];
         bus.req_op1[i] = op1_a[i];
         bus.req_op2[i] = op2_a[i];
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      bus.calc_resp = 2'd0;
      @(negedge c_clk);
      @(negedge c_clk);
      vmask = '0;
      drive_reqs();
      reset = 1'b1;
      ptr = N - 1;
   endtask

   // wait (bounded) for a grant; returns the observed granted index or -1
   task automatic wait_grant(output int obs);
      int n;
      drive_reqs();
      #1;
      n = 0;
      while (bus.req_ready == '0 && n < 20) begin
         @(negedge c_clk);
         drive_reqs();
         #1;
         n++;
      end
      obs = -1;
      for (int i = 0; i < N; i++) if (bus.req_ready[i]) obs = i;
   endtask

   // one full transaction; CALC1 answers dly WAIT cycles after entering WAIT
   task automatic run_one(input int dly, input logic [1:0] rcode, input logic [31:0] rdata,
                          input bit spur, output int g);
      int          exp_g;
      logic [3:0]  exp_oh;
      logic [3:0]  c;
      logic [31:0] o1, o2;
      exp_g = -1;
      for (int i = 1; i <= N; i++) begin
         int k;
         k = (ptr + i) % N;
         if (exp_g < 0 && vmask[k]) exp_g = k;
      end
      if (exp_g < 0) exp_g = 0;
      exp_oh = 4'(1 << exp_g);
      c  = cmd_a[exp_g];
      o1 = op1_a[exp_g];
      o2 = op2_a[exp_g];
      wait_grant(g);
      chk("grant_oh", {28'd0, bus.req_ready}, {28'd0, exp_oh});
      chk("busy_idle", {31'd0, busy}, 32'd0);
      @(negedge c_clk);                                   // N+1
      chk("rdy_pulse", {28'd0, bus.req_ready}, 32'd0);
      chk("busy_act", {31'd0, busy}, 32'd1);
      // requests are latched: scrambling them now must not matter
      bus.req_valid = 4'($urandom);
      bus.req_cmd   = 16'($urandom);
      bus.req_op1   = {$urandom, $urandom, $urandom, $urandom};
      bus.req_op2   = {$urandom, $urandom, $urandom, $urandom};
      if (c == 4'd0) begin
         chk("nop_cmd", {28'd0, bus.calc_cmd}, 32'd0);
         chk("nop_din", bus.calc_data_in, 32'd0);
         @(negedge c_clk);                                // N+2
         chk("nop_cmd2", {28'd0, bus.calc_cmd}, 32'd0);
         chk("nop_rspv", {28'd0, bus.rsp_valid}, {28'd0, exp_oh});
         chk("nop_resp", {30'd0, bus.rsp_resp}, 32'd2);
         chk("nop_data", bus.rsp_data, 32'd0);
      end else begin
         chk("cmd_n1", {28'd0, bus.calc_cmd}, {28'd0, c});
         chk("op1_n1", bus.calc_data_in, o1);
         @(negedge c_clk);                                // N+2
         chk("cmd_n2", {28'd0, bus.calc_cmd}, 32'd0);
         chk("op2_n2", bus.calc_data_in, o2);
         if (spur) begin
            bus.calc_resp     = 2'd1;
            bus.calc_data_out = 32'hdead_beef;
         end
         @(negedge c_clk);                                // N+3, first WAIT cycle
         bus.calc_resp     = 2'd0;
         bus.calc_data_out = 32'd0;
         for (int d = 0; d < dly; d++) begin
            chk("wait_rspv", {28'd0, bus.rsp_valid}, 32'd0);
            chk("wait_bus", {bus.calc_cmd, bus.calc_data_in[27:0]}, 32'd0);
            @(negedge c_clk);
         end
         chk("wait_rspv_k", {28'd0, bus.rsp_valid}, 32'd0);
         bus.calc_resp     = rcode;                       // cycle K
         bus.calc_data_out = rdata;
         @(negedge c_clk);                                // K+1
         bus.calc_resp     = 2'd0;
         bus.calc_data_out = $urandom;
         chk("rsp_valid", {28'd0, bus.rsp_valid}, {28'd0, exp_oh});
         chk("rsp_resp", {30'd0, bus.rsp_resp}, {30'd0, rcode});
         chk("rsp_data", bus.rsp_data, rdata);
      end
      drive_reqs();
      #1;
      chk("no_grant_rsp", {28'd0, bus.req_ready}, 32'd0);
      ptr = exp_g;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      int cnt;
      bit seen;
      total = 0;
      bad   = 0;
      ptr   = N - 1;
      reset = 1'b0;
      vmask = 4'hF;
      for (int i = 0; i < N; i++) begin
         cmd_a[i] = 4'd1;
         op1_a[i] = $urandom;
         op2_a[i] = $urandom;
      end
      bus.calc_resp     = 2'd0;
      bus.calc_data_out = 32'd0;
      drive_reqs();

      // reset state (requests pending but reset held)
      repeat (3) @(negedge c_clk);
      chk("rst_ready", {28'd0, bus.req_ready}, 32'd0);
      chk("rst_rspv", {28'd0, bus.rsp_valid}, 32'd0);
      chk("rst_cmd", {28'd0, bus.calc_cmd}, 32'd0);
      chk("rst_din", bus.calc_data_in, 32'd0);
      chk("rst_resp", {30'd0, bus.rsp_resp}, 32'd0);
      chk("rst_data", bus.rsp_data, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
      vmask = '0;
      drive_reqs();
      reset = 1'b1;

      // requester 0 add 1+2, CALC1 answers ok/3 after 3 WAIT cycles
      vmask = 4'b0001; cmd_a[0] = 4'd1; op1_a[0] = 32'h1; op2_a[0] = 32'h2;
      run_one(3, 2'd1, 32'h3, 1'b0, g);
      chk("add_grant", g, 0);

      // all four requesting: grant order 0,1,2,3,0,1,2,3 after reset
      do_reset();
      vmask = 4'hF;
      for (int i = 0; i < N; i++) cmd_a[i] = 4'(i + 1);
      for (int k = 0; k < 8; k++) begin
         run_one($urandom_range(0, 3), 2'd1, $urandom, 1'b0, g);
         chk("rr_order", g, k % N);
      end

      // nop from requester 2
      vmask = 4'b0100; cmd_a[2] = 4'd0;
      run_one(0, 2'd1, 32'd0, 1'b0, g);
      chk("nop_grant", g, 2);

      // spurious ok during OP2, real err in WAIT
      vmask = 4'b0001; cmd_a[0] = 4'd2; op1_a[0] = 32'h10; op2_a[0] = 32'h4;
      run_one(2, 2'd2, 32'h55, 1'b1, g);

      // randomized traffic, including invalid and nop codes
      for (int t = 0; t < 40; t++) begin
         vmask = 4'($urandom_range(1, 15));
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) cmd_a[i] = 4'($urandom);
            op1_a[i] = $urandom;
            op2_a[i] = $urandom;
         end
         run_one($urandom_range(0, 6), 2'($urandom_range(1, 3)), $urandom,
                 1'($urandom_range(0, 1)), g);
      end

      // reset while waiting for CALC1
      vmask = 4'hF;
      for (int i = 0; i < N; i++) cmd_a[i] = 4'd1;
      wait_grant(g);
      @(negedge c_clk); @(negedge c_clk); @(negedge c_clk);
      chk("rw_busy", {31'd0, busy}, 32'd1);
      reset = 1'b0;
      bus.calc_resp = 2'd1;
      bus.calc_data_out = 32'h77;
      bus.req_valid = '0;
      @(negedge c_clk);
      chk("rw_rspv", {28'd0, bus.rsp_valid}, 32'd0);
      chk("rw_busy0", {31'd0, busy}, 32'd0);
      chk("rw_cmd", {28'd0, bus.calc_cmd}, 32'd0);
      reset = 1'b1;
      bus.calc_resp = 2'd0;
      @(negedge c_clk);
      chk("rw_rspv2", {28'd0, bus.rsp_valid}, 32'd0);
      ptr = N - 1;
      run_one(1, 2'd1, 32'h9, 1'b0, g);
      chk("rw_first", g, 0);

      // WAIT with no CALC1 answer
      vmask = 4'b0001; cmd_a[0] = 4'd5;
      wait_grant(g);
      chk("tw_grant", g, 0);
      @(negedge c_clk); @(negedge c_clk);                 // N+2
`ifdef CALC1_SCHED_TIMEOUT_EN
      cnt = 0; seen = 1'b0;
      while (!seen && cnt < 200) begin
         @(negedge c_clk);
         cnt++;
         if (bus.rsp_valid != '0) seen = 1'b1;
      end
      chk("tmo_lat", cnt, 65);
      chk("tmo_rspv", {28'd0, bus.rsp_valid}, 32'd1);
      chk("tmo_resp", {30'd0, bus.rsp_resp}, 32'd3);
      chk("tmo_data", bus.rsp_data, 32'd0);
      chk("tmo_err", {31'd0, timeout_err}, 32'd1);
      ptr = 0;
      vmask = 4'b0010; cmd_a[1] = 4'd1;
      run_one(1, 2'd1, 32'h5, 1'b0, g);
      chk("tmo_sticky", {31'd0, timeout_err}, 32'd1);
      do_reset();
      chk("tmo_clr", {31'd0, timeout_err}, 32'd0);
`else
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge c_clk);
         if (bus.rsp_valid != '0) cnt++;
      end
      chk("hold_rspv", cnt, 0);
      chk("hold_busy", {31'd0, busy}, 32'd1);
      chk("hold_tmo", {31'd0, timeout_err}, 32'd0);
      do_reset();
      chk("hold_rst", {31'd0, busy}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
